// File: rtl/spinner_pkg.sv
// spinner_pkg
// Shared definitions for the Arkanoid spinner controller: quadrature phase
// constants, the step direction type, the phase sequencer and the
// saturating accumulator add.
package spinner_pkg;

  // Quadrature {A,B} phases. The controller parks on QUAD_RESET after reset.
  localparam logic [1:0] QUAD_00    = 2'b00;
  localparam logic [1:0] QUAD_01    = 2'b01;
  localparam logic [1:0] QUAD_11    = 2'b11;
  localparam logic [1:0] QUAD_10    = 2'b10;
  localparam logic [1:0] QUAD_RESET = 2'b11;

  typedef enum logic {
    DIR_POS = 1'b0,
    DIR_NEG = 1'b1
  } dir_e;

  // Positive rotation walks 00->10->11->01->00; negative walks the reverse.
  function automatic logic [1:0] quad_next(input logic [1:0] phase, input dir_e neg);
    logic [1:0] nxt;
    case (phase)
      QUAD_00: nxt = (neg == DIR_NEG) ? QUAD_01 : QUAD_10;
      QUAD_10: nxt = (neg == DIR_NEG) ? QUAD_00 : QUAD_11;
      QUAD_11: nxt = (neg == DIR_NEG) ? QUAD_10 : QUAD_01;
      default: nxt = (neg == DIR_NEG) ? QUAD_11 : QUAD_00;
    endcase
    return nxt;
  endfunction

  // Symmetric saturation: the most negative code is never produced, so the
  // accumulator range is +/-(2^(acc_w-1)-1).
  function automatic int sat_add(input int a, input int d, input int acc_w);
    int lim;
    int s;
    lim = (1 << (acc_w - 1)) - 1;
    s   = a + d;
    if (s > lim) begin
      s = lim;
    end else if (s < -lim) begin
      s = -lim;
    end
    return s;
  endfunction

endpackage

// File: rtl/spinner_joy_repeat.sv
// spinner_joy_repeat
// Converts a held joystick left/right into periodic signed step bursts.
// Ports:
//   clk_12m    system clock
//   reset      synchronous active-high reset
//   joy_right  held for positive motion
//   joy_left   held for negative motion
//   joy_fast   selects JOY_FAST steps per event instead of JOY_SLOW
//   delta_j    signed step count for this cycle (zero when no event)
module spinner_joy_repeat
  import spinner_pkg::*;
#(
  parameter int JOY_PERIOD = 96000,
  parameter int JOY_SLOW   = 4,
  parameter int JOY_FAST   = 9,
  parameter int DELTA_W    = 13
) (
  input  logic                      clk_12m,
  input  logic                      reset,
  input  logic                      joy_right,
  input  logic                      joy_left,
  input  logic                      joy_fast,
  output logic signed [DELTA_W-1:0] delta_j
);

  localparam int                      TW   = (JOY_PERIOD > 1) ? $clog2(JOY_PERIOD) : 1;
  localparam logic [TW-1:0]           LAST = TW'(JOY_PERIOD - 1);
  localparam logic signed [DELTA_W-1:0] SLOW = DELTA_W'(JOY_SLOW);
  localparam logic signed [DELTA_W-1:0] FAST = DELTA_W'(JOY_FAST);

  logic [TW-1:0]              joy_timer;
  logic                       one_held;
  logic                       wrap;
  logic signed [DELTA_W-1:0]  mag;

  // Neither or both directions held means no intended motion, so the timer
  // restarts and the first burst only comes a full period after a press.
  assign one_held = joy_right ^ joy_left;
  assign wrap     = one_held && (joy_timer == LAST);
  assign mag      = joy_fast ? FAST : SLOW;

  always_ff @(posedge clk_12m) begin
    if (reset || !one_held || wrap) begin
      joy_timer <= '0;
    end else begin
      joy_timer <= joy_timer + TW'(1);
    end
  end

  always_comb begin
    delta_j = '0;
    if (wrap) begin
      delta_j = joy_right ? mag : -mag;
    end
  end

endmodule

// File: rtl/spinner_ctrl.sv
// spinner_ctrl
// Merges PS/2 mouse X motion and joystick auto-repeat into a signed pending
// step accumulator and drains it as quadrature phases at a fixed step rate.
// Ports:
//   clk_12m       system clock
//   reset         synchronous active-high reset
//   mouse_strobe  toggles once per new mouse packet
//   mouse_dx      9-bit two's complement X delta
//   joy_right     held for positive motion
//   joy_left      held for negative motion
//   joy_fast      larger joystick bursts
//   spinner       quadrature {A,B} to the core
//   busy          pending steps remain
//   dir           direction of the last emitted step, 1 = negative
module spinner_ctrl
  import spinner_pkg::*;
#(
  parameter int ACC_W      = 12,
  parameter int STEP_DIV   = 1000,
  parameter int JOY_PERIOD = 96000,
  parameter int JOY_SLOW   = 4,
  parameter int JOY_FAST   = 9
) (
  input  logic       clk_12m,
  input  logic       reset,
  input  logic       mouse_strobe,
  input  logic [8:0] mouse_dx,
  input  logic       joy_right,
  input  logic       joy_left,
  input  logic       joy_fast,
  output logic [1:0] spinner,
  output logic       busy,
  output logic       dir
);

  localparam int                      DW        = ACC_W + 1;
  localparam int                      SW        = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [SW-1:0]           STEP_LAST = SW'(STEP_DIV - 1);
  localparam logic signed [ACC_W-1:0] ONE       = ACC_W'(1);

  logic                     strobe_prev;
  logic                     mouse_evt;
  logic                     tick;
  logic                     step;
  logic                     acc_neg;
  logic                     flush;
  logic [SW-1:0]            step_timer;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  a1;
  logic signed [ACC_W-1:0]  acc_next;
  logic signed [DW-1:0]     delta_m;
  logic signed [DW-1:0]     delta_j;
  logic signed [DW-1:0]     delta;

  spinner_joy_repeat #(
    .JOY_PERIOD (JOY_PERIOD),
    .JOY_SLOW   (JOY_SLOW),
    .JOY_FAST   (JOY_FAST),
    .DELTA_W    (DW)
  ) u_joy (
    .clk_12m   (clk_12m),
    .reset     (reset),
    .joy_right (joy_right),
    .joy_left  (joy_left),
    .joy_fast  (joy_fast),
    .delta_j   (delta_j)
  );

  assign mouse_evt = mouse_strobe ^ strobe_prev;
  assign delta_m   = mouse_evt ? DW'(signed'(mouse_dx)) : '0;
  assign delta     = delta_m + delta_j;
  assign tick      = (step_timer == STEP_LAST);
  assign acc_neg   = acc[ACC_W-1];
  assign step      = tick && (acc != '0);

  // The step is taken first, then the new motion is applied to what is left.
  // Motion against the remaining direction throws the remainder away so the
  // paddle reacts to a reversal immediately instead of finishing old travel.
  always_comb begin
    a1 = acc;
    if (step) begin
      a1 = acc_neg ? (acc + ONE) : (acc - ONE);
    end
    flush = (a1 != '0) && (delta != '0) && (a1[ACC_W-1] != delta[DW-1]);
    if (flush) begin
      acc_next = ACC_W'(sat_add(0, int'(delta), ACC_W));
    end else begin
      acc_next = ACC_W'(sat_add(int'(a1), int'(delta), ACC_W));
    end
  end

  // strobe_prev captures the live strobe level during reset so the first
  // cycle afterwards never sees a phantom mouse packet.
  always_ff @(posedge clk_12m) begin
    if (reset) begin
      step_timer  <= '0;
      strobe_prev <= mouse_strobe;
      acc         <= '0;
      busy        <= 1'b0;
      dir         <= 1'b0;
      spinner     <= QUAD_RESET;
    end else begin
      strobe_prev <= mouse_strobe;
      step_timer  <= tick ? '0 : (step_timer + SW'(1));
      acc         <= acc_next;
      busy        <= (acc_next != '0);
      if (step) begin
        spinner <= quad_next(spinner, acc_neg ? DIR_NEG : DIR_POS);
        dir     <= acc_neg;
      end
    end
  end

endmodule

// File: tb/tb_spinner_ctrl.sv
// tb_spinner_ctrl
// Scoreboard bench: an integer reference model predicts every spinner phase
// change into a queue, a negedge monitor pops and compares as the DUT moves.
module tb_spinner_ctrl;

  localparam int ACC_W      = 12;
  localparam int STEP_DIV   = 4;
  localparam int JOY_PERIOD = 16;
  localparam int JOY_SLOW   = 4;
  localparam int JOY_FAST   = 9;
  localparam int ACC_LIM    = 2047;
  localparam logic [1:0] PHASE_OF [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

  logic       clk_12m      = 1'b0;
  logic       reset        = 1'b1;
  logic       mouse_strobe = 1'b1;
  logic [8:0] mouse_dx     = '0;
  logic       joy_right    = 1'b0;
  logic       joy_left     = 1'b0;
  logic       joy_fast     = 1'b0;
  logic [1:0] spinner;
  logic       busy;
  logic       dir;

  int checks   = 0;
  int failures = 0;

  spinner_ctrl #(
    .ACC_W      (ACC_W),
    .STEP_DIV   (STEP_DIV),
    .JOY_PERIOD (JOY_PERIOD),
    .JOY_SLOW   (JOY_SLOW),
    .JOY_FAST   (JOY_FAST)
  ) dut (
    .clk_12m      (clk_12m),
    .reset        (reset),
    .mouse_strobe (mouse_strobe),
    .mouse_dx     (mouse_dx),
    .joy_right    (joy_right),
    .joy_left     (joy_left),
    .joy_fast     (joy_fast),
    .spinner      (spinner),
    .busy         (busy),
    .dir          (dir)
  );

  always #5 clk_12m = ~clk_12m;

  // Reference model: the spinner is an integer position, the phase is a
  // lookup of position mod 4, pending motion is a plain integer.
  int         m_acc  = 0;
  int         m_pos  = 2;
  int         m_cyc  = 0;
  int         m_held = 0;
  bit         m_dir  = 1'b0;
  bit         m_prev = 1'b1;
  int         dm, dj, delta, a1;
  bit         tick;
  logic [1:0] exp_q [$];
  bit         mon_en = 1'b0;
  logic [1:0] last_spin;

  function automatic int clamp(input int v);
    if (v > ACC_LIM) return ACC_LIM;
    if (v < -ACC_LIM) return -ACC_LIM;
    return v;
  endfunction

  function automatic logic [1:0] phase_at(input int p);
    return PHASE_OF[((p % 4) + 4) % 4];
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Model advances on the same edge the DUT does, using that cycle's inputs.
  always @(posedge clk_12m) begin
    if (reset) begin
      if (phase_at(m_pos) != 2'b11) exp_q.push_back(2'b11);
      m_pos  = 2;
      m_acc  = 0;
      m_dir  = 1'b0;
      m_cyc  = 0;
      m_held = 0;
      m_prev = mouse_strobe;
    end else begin
      tick = (m_cyc % STEP_DIV) == (STEP_DIV - 1);
      m_cyc++;
      dm = 0;
      if (mouse_strobe != m_prev) dm = mouse_dx[8] ? int'(mouse_dx) - 512 : int'(mouse_dx);
      m_prev = mouse_strobe;
      dj = 0;
      if (joy_right != joy_left) begin
        m_held++;
        if (m_held % JOY_PERIOD == 0) begin
          dj = joy_fast ? JOY_FAST : JOY_SLOW;
          if (joy_left) dj = -dj;
        end
      end else begin
        m_held = 0;
      end
      delta = dm + dj;
      a1 = m_acc;
      if (tick && m_acc != 0) begin
        m_dir = (m_acc < 0);
        m_pos = m_pos + (m_dir ? -1 : 1);
        a1 = m_acc + (m_dir ? 1 : -1);
        exp_q.push_back(phase_at(m_pos));
      end
      if (a1 != 0 && delta != 0 && ((a1 < 0) != (delta < 0))) m_acc = clamp(delta);
      else m_acc = clamp(a1 + delta);
    end
  end

  // Monitor: any phase change must match the next predicted phase, and no
  // predicted phase may be left unconsumed after the edge that produced it.
  always @(negedge clk_12m) begin
    if (mon_en) begin
      if (spinner != last_spin) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_step: got %b expected no change at %0t", spinner, $time);
        end else begin
          checkOutput("spinner_phase", int'(spinner), int'(exp_q.pop_front()));
        end
        last_spin = spinner;
      end
      if (exp_q.size() != 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL missed_step: got %b expected %b at %0t", spinner, exp_q[0], $time);
        exp_q.delete();
      end
      checkOutput("busy", int'(busy), int'(m_acc != 0));
      checkOutput("dir", int'(dir), int'(m_dir));
      checkOutput("acc", int'(dut.acc), m_acc);
    end
  end

  task automatic nextCycle();
    @(posedge clk_12m);
    #1;
  endtask

  // One mouse packet: new dx plus a strobe toggle, held for one cycle.
  task automatic applyStimulus(input int dx);
    mouse_dx     = 9'(dx);
    mouse_strobe = ~mouse_strobe;
    nextCycle();
  endtask

  task automatic waitIdle(input int budget, input string name);
    int n;
    n = 0;
    while (busy && n < budget) begin
      nextCycle();
      n++;
    end
    checkOutput(name, int'(busy), 0);
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [1:0] start;
    int n;
    int tmp;

    repeat (3) nextCycle();
    reset     = 1'b0;
    last_spin = spinner;
    mon_en    = 1'b1;

    // Idle after reset with the strobe high throughout.
    repeat (50) nextCycle();
    checkOutput("idle_spinner", int'(spinner), 3);
    checkOutput("idle_busy", int'(busy), 0);
    checkOutput("idle_dir", int'(dir), 0);

    // Small positive packet drains in three positive steps.
    applyStimulus(3);
    checkOutput("busy_after_event", int'(busy), 1);
    waitIdle(40, "drain_plus3");
    checkOutput("plus3_phase", int'(spinner), 2);
    checkOutput("plus3_dir", int'(dir), 0);

    // Reversal after one step flushes the remaining positive travel.
    applyStimulus(5);
    start = spinner;
    n = 0;
    while (spinner == start && n < 10) begin
      nextCycle();
      n++;
    end
    checkOutput("first_step_phase", int'(spinner), 3);
    applyStimulus(-2);
    checkOutput("flush_acc", int'(dut.acc), -2);
    waitIdle(40, "drain_flush");
    checkOutput("flush_phase", int'(spinner), 0);
    checkOutput("flush_dir", int'(dir), 1);

    // Joystick repeat, slow then fast.
    for (int f = 0; f < 2; f++) begin
      joy_fast  = f[0];
      joy_right = 1'b1;
      for (int i = 1; i <= 40; i++) begin
        nextCycle();
        if (i == 15) checkOutput("joy_before_event", int'(dut.acc), 0);
        if (i == 16) checkOutput("joy_first_event", int'(dut.acc), f ? JOY_FAST : JOY_SLOW);
      end
      joy_right = 1'b0;
      waitIdle(100, "drain_joy");
    end
    joy_fast = 1'b0;

    // Both directions held: timer pinned at zero, nothing accumulates.
    joy_right = 1'b1;
    joy_left  = 1'b1;
    for (int i = 0; i < 40; i++) begin
      nextCycle();
      checkOutput("joy_both_timer", int'(dut.u_joy.joy_timer), 0);
    end
    joy_right = 1'b0;
    joy_left  = 1'b0;

    // Mouse +3 and joystick -4 on a tick with two steps pending.
    n = 0;
    while ((m_cyc % STEP_DIV) != 0 && n < 8) begin
      nextCycle();
      n++;
    end
    joy_left = 1'b1;
    repeat (13) nextCycle();
    applyStimulus(2);
    nextCycle();
    applyStimulus(3);
    joy_left = 1'b0;
    checkOutput("same_cycle_flush", int'(dut.acc), -1);
    waitIdle(40, "drain_same_cycle");

    // Burst of full-scale packets saturates without wrapping.
    for (int i = 0; i < 10; i++) applyStimulus(255);
    checkOutput("clamp_acc", int'(dut.acc), ACC_LIM);
    repeat (20) nextCycle();

    // Reset in the middle of the drain.
    reset = 1'b1;
    nextCycle();
    checkOutput("rst_spinner", int'(spinner), 3);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_dir", int'(dir), 0);
    checkOutput("rst_acc", int'(dut.acc), 0);
    reset = 1'b0;

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 9) == 0) begin
          mouse_dx = 9'($urandom);
        end else begin
          tmp = int'($urandom_range(0, 40)) - 20;
          mouse_dx = 9'(tmp);
        end
        mouse_strobe = ~mouse_strobe;
      end
      if ($urandom_range(0, 19) == 0) begin
        joy_right = 1'($urandom_range(0, 1));
        joy_left  = 1'($urandom_range(0, 1));
        joy_fast  = 1'($urandom_range(0, 1));
      end
      reset = ($urandom_range(0, 299) == 0);
      nextCycle();
    end
    reset     = 1'b0;
    joy_right = 1'b0;
    joy_left  = 1'b0;
    waitIdle(20000, "drain_random");
    nextCycle();
    checkOutput("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
